// File: rtl/binom_row_seq_pkg.sv
// Shared definitions for the Pascal-row sequencer: ALU op codes, widths and FSM states.
package binom_row_seq_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_DIV = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    EMIT,
    SUB,
    MUL,
    INC,
    DIV
  } state_e;

endpackage

// File: rtl/binom_row_seq_alu.sv
// Team 32-bit combinational ALU: arithmetic ops plus basic logic ops and a zero flag.
module binom_row_seq_alu
  import binom_row_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zf
);

  always_comb begin
    y = '0;
    case (sel)
      4'b0000: y = a & b;
      4'b0001: y = a | b;
      4'b0010: y = a ^ b;
      4'b0011: y = ~a;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      // A zero divisor yields zero rather than an undefined result.
      OP_DIV:  y = (b == '0) ? '0 : a / b;
      default: y = '0;
    endcase
  end

  assign zf = (y == '0);

endmodule

// File: rtl/binom_row_seq.sv
// Streams row n of Pascal's triangle using C(n,i) = C(n,i-1)*(n-i+1)/i,
// one shared-ALU operation per cycle, over a valid/ready output.
module binom_row_seq
  import binom_row_seq_pkg::*;
#(
  parameter int N_W  = 5,
  parameter int NMAX = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   n,
  output logic             busy,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] out_data,
  output logic [N_W-1:0]   out_idx,
  output logic             out_last,
  output logic             done
);

  localparam logic [N_W-1:0] NMAX_V = N_W'(NMAX);

  state_e             state_q, state_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [N_W-1:0]     i_q, i_d;
  logic [ALU_W-1:0]   acc_q, acc_d;
  logic [ALU_W-1:0]   t_q, t_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic [3:0]         alu_sel;
  logic [ALU_W-1:0]   alu_a, alu_b, alu_y;
  logic               alu_zf_unused;

  function automatic logic [ALU_W-1:0] zext(input logic [N_W-1:0] v);
    return {{(ALU_W-N_W){1'b0}}, v};
  endfunction

  binom_row_seq_alu #(.DATA_W(ALU_W)) u_alu (
    .sel (alu_sel),
    .a   (alu_a),
    .b   (alu_b),
    .y   (alu_y),
    .zf  (alu_zf_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
      acc_q   <= ALU_W'(1);
      t_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      t_q     <= t_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    i_d       = i_q;
    acc_d     = acc_q;
    t_d       = t_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    alu_sel   = OP_ADD;
    alu_a     = '0;
    alu_b     = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n > NMAX_V) begin
            err_d = 1'b1;
          end else begin
            n_d     = n;
            i_d     = '0;
            acc_d   = ALU_W'(1);
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_data  = acc_q;
        out_idx   = i_q;
        out_last  = (i_q == n_q);
        if (out_ready) begin
          if (i_q == n_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = SUB;
          end
        end
      end
      SUB: begin
        alu_sel = OP_SUB;
        alu_a   = zext(n_q);
        alu_b   = zext(i_q);
        t_d     = alu_y;
        state_d = MUL;
      end
      MUL: begin
        alu_sel = OP_MUL;
        alu_a   = acc_q;
        alu_b   = t_q;
        acc_d   = alu_y;
        state_d = INC;
      end
      INC: begin
        alu_sel = OP_ADD;
        alu_a   = zext(i_q);
        alu_b   = ALU_W'(1);
        i_d     = alu_y[N_W-1:0];
        state_d = DIV;
      end
      DIV: begin
        // i already holds the new index here, so it is never zero.
        alu_sel = OP_DIV;
        alu_a   = acc_q;
        alu_b   = zext(i_q);
        acc_d   = alu_y;
        state_d = EMIT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign err  = err_q;
  assign done = done_q;

endmodule

// File: tb/tb_binom_row_seq.sv
// Directed bench for binom_row_seq: a Pascal-addition model fills a scoreboard
// that a negedge monitor drains on each output handshake.
module tb_binom_row_seq;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  idx;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  n = '0;
  logic        busy, err, out_valid, out_last, done;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_idx;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  beat_t sb[$];
  bit    per_chk = 0;
  int    beats = 0;
  int    last_hs = 0;
  bit    done_pend = 0;
  int    done_due = 0;

  binom_row_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n         (n),
    .busy      (busy),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Independent reference: build row nv by repeated Pascal additions.
  task automatic push_row(input int nv);
    longint r[0:31];
    beat_t  e;
    for (int j = 0; j < 32; j++) r[j] = 0;
    r[0] = 1;
    for (int k = 1; k <= nv; k++)
      for (int j = k; j >= 1; j--) r[j] = r[j] + r[j-1];
    for (int j = 0; j <= nv; j++) begin
      e.d    = r[j][31:0];
      e.idx  = 5'(j);
      e.last = (j == nv);
      if (r[j] > 64'd4294967295) chk("model_range", r[j], 0);
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (err) chk("err_with_valid", out_valid, 0);
      if (done_pend && cyc == done_due) begin
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        done_pend = 0;
      end else if (done) begin
        chk("spurious_done", done, 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("beat_expected", 64'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_idx", out_idx, e.idx);
          chk("out_last", out_last, e.last);
          if (per_chk && beats > 0) chk("period", cyc - last_hs, 5);
          last_hs = cyc;
          beats++;
          if (e.last) begin
            done_pend = 1;
            done_due  = cyc + 1;
          end
        end
      end
    end
  end

  task automatic start_row(input int nv);
    beats = 0;
    if (nv <= 30) push_row(nv);
    @(posedge clk); #1;
    start = 1'b1;
    n     = 5'(nv);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    if (nv <= 30) chk("first_valid", out_valid, 1);
  endtask

  task automatic wait_done(input int budget);
    bit got = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk("done_timeout", got, 1);
    chk("sb_empty", 64'(sb.size()), 0);
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    chk("valid_timeout", ok, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, err, out_valid, out_data, out_idx, out_last, done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // n=4, free-running consumer
    out_ready = 1'b1;
    per_chk   = 1;
    start_row(4);
    wait_done(60);

    // n=0, single beat
    start_row(0);
    wait_done(20);
    @(negedge clk);
    chk("busy_after_done", busy, 0);

    // n=30, widest row
    start_row(30);
    wait_done(300);

    // n=31 rejected
    per_chk = 0;
    start_row(31);
    chk("err_pulse", err, 1);
    chk("busy_on_err", busy, 0);
    @(negedge clk);
    chk("err_one_cycle", err, 0);
    chk("busy_after_err", busy, 0);
    repeat (3) @(negedge clk);
    chk("no_valid_after_err", out_valid, 0);

    // n=5 with a stall on index 2 and a start issued mid-row
    @(posedge clk); #1;
    out_ready = 1'b0;
    start_row(5);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) wait_valid();
      if (k == 2) begin
        chk("stall_data0", out_data, 10);
        chk("stall_idx0", out_idx, 2);
        for (int s = 0; s < 7; s++) begin
          @(posedge clk); #1;
          start = (s == 2);
          n     = (s == 2) ? 5'd3 : n;
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, 10);
          chk("stall_idx", out_idx, 2);
          chk("stall_last", out_last, 0);
        end
      end
      @(posedge clk); #1;
      start     = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    wait_done(20);

    // asynchronous reset while in MUL of n=6
    out_ready = 1'b1;
    start_row(6);
    @(posedge clk);
    @(posedge clk); #2;
    chk("busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {busy, err, out_valid, out_data, out_idx, out_last, done}, 0);
    sb.delete();
    done_pend = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("no_done_after_rst", done, 0);

    // clean restart with n=2
    start_row(2);
    wait_done(40);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/binom_row_seq.md
Name: binom_row_seq

Overview:
Sequencer that drives one instance of the team's 32-bit ALU to produce row n of Pascal's triangle, C(n,0) through C(n,n), for the binomial-theorem datapath.
- Uses the recurrence C(n,i) = C(n,i-1)*(n-i+1)/i, issuing exactly one ALU operation per cycle.
- Streams coefficients out over a valid/ready interface, one coefficient per handshake, with index and last flag.
- Sits between the top-level expansion controller (which supplies n and start) and the term generator (which consumes coefficients).

Parameters:
N_W, 5, width of n and out_idx
NMAX, 30, largest accepted n; every intermediate i*C(n,i) stays below 2^32 for n <= 30

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
n  in  N_W  row number, sampled with start
busy  out  1  high in every state except IDLE
err  out  1  one-cycle pulse: start with n > NMAX
out_valid  out  1  coefficient available
out_ready  in  1  consumer accepts
out_data  out  32  C(n,out_idx)
out_idx  out  N_W  coefficient index i
out_last  out  1  out_idx == n, qualified by out_valid
done  out  1  one-cycle pulse after the last coefficient is accepted

Behaviour:
Reset (asynchronous, any state): state = IDLE; acc = 1; i = 0; t = 0. All outputs 0 (busy, err, out_valid, out_data, out_idx, out_last, done). A stream in progress is abandoned with no done pulse.

Registers: n_r (N_W bits), acc (32 bits), i (N_W bits), t (32 bits). ALU operands are zero-extended to 32 bits.

ALU op codes:
- 0100 add
- 0101 sub
- 0110 mul
- 0111 div
- ALU zf is unused.

FSM:
- IDLE:
  - start & n <= NMAX: n_r = n, acc = 1, i = 0, go to EMIT.
  - start & n > NMAX: err = 1 for the next cycle, stay in IDLE.
  - Otherwise stay in IDLE.
- EMIT:
  - Drive out_valid = 1, out_data = acc, out_idx = i, out_last = (i == n_r).
  - Hold every output stable until out_ready.
  - On a handshake with out_last: go to IDLE; done pulses for the following cycle.
  - On a handshake without out_last: go to SUB.
- SUB: ALU sub, n_r - i. Result into t.
- MUL: ALU mul, acc * t. Result into acc.
- INC: ALU add, i + 1. Result into i.
- DIV: ALU div, acc / i. Result into acc; the division is exact. Go to EMIT.

Timing:
- First out_valid is asserted in the cycle after the start edge.
- After an accepting edge, out_valid reasserts 4 cycles later. The coefficient period is 5 cycles with out_ready held high.

Boundary conditions:
- n = 0: a single coefficient 1, with out_idx = 0 and out_last = 1.
- start while busy is ignored; n is not re-sampled.
- Backpressure may last any number of cycles with no change to the outputs.
- err and out_valid are never asserted together.
- Division by zero is impossible: i >= 1 whenever DIV runs.

Decomposition:
- Shared package/header holds:
  - ALU op-code constants: OP_ADD = 4'b0100, OP_SUB = 4'b0101, OP_MUL = 4'b0110, OP_DIV = 4'b0111.
  - State encoding: IDLE, EMIT, SUB, MUL, INC, DIV.
- One sub-module: the existing ALU, instantiated once.
  - Its sel input is driven combinationally from the state.
  - Its operands are muxed from n_r, i, acc, t and the constant 1.

Test Plan:
- n=4, out_ready=1 -> out_data 1,4,6,4,1; out_idx 0..4; out_last only on idx 4; 5 cycles between valids; done one cycle after the last handshake.
- n=0 -> single beat: data 1, idx 0, last 1; then done; busy low the cycle after done.
- n=30 -> idx 15 data 155117520, idx 16 data 145422675, idx 30 data 1 with last; no wrap (value of 4294967295 or below at every beat).
- n=31 -> err high for exactly one cycle; out_valid never asserted; busy stays 0.
- n=5 with out_ready low for 7 cycles on idx 2 -> data 10, idx 2 held stable for the whole stall; a second start with n=3 mid-row is ignored; stream continues 10,5,1.
- rst asserted during MUL of n=6 -> all outputs 0 immediately, without waiting for a clock edge; next start with n=2 yields 1,2,1.
